// File: rtl/ysyx_24080014_lsu_if.sv
// Pipeline-side and bus-side signals of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface ysyx_24080014_lsu_if;
  // Every channel uses the same rule: a transfer happens on a rising edge where
  // valid and ready are both 1. Once valid rises, it and its payload stay put
  // until that edge. Ready may depend on valid. The response channel has no ready.
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_err;

  logic [1:0]  dbg_state;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output out_valid, out_data, out_rd, out_wen, out_err,
    input  out_ready,
    output dbg_state
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  out_valid, out_data, out_rd, out_wen, out_err,
    output out_ready,
    input  dbg_state
  );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Single-outstanding load/store unit: accepts one instruction, performs at most one
// bus access, and presents the write-back result until it is taken.
module ysyx_24080014_lsu (
  input logic                  clk,
  input logic                  rst,
  ysyx_24080014_lsu_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic        ld_q, st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] res_data_q;
  logic        res_wen_q, res_err_q;

  logic        accept;
  logic        is_mem, bad_f3, misaligned, acc_err;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [3:0]  lane_mask;

  assign accept = bus.in_valid && (state == S_IDLE);
  assign is_mem = bus.in_is_load || bus.in_is_store;

  // funct3 011/110/111 have no size meaning for memory ops.
  assign bad_f3 = (bus.in_funct3 == 3'b011) || (bus.in_funct3 == 3'b110) ||
                  (bus.in_funct3 == 3'b111);
  assign misaligned = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                      ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
  assign acc_err = is_mem &&
                   ((bus.in_is_load && bus.in_is_store) || bad_f3 || misaligned);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (is_mem && !acc_err) ? S_REQ : S_DONE;
      S_REQ:  if (bus.mem_req_ready) state_next = S_WAIT;
      S_WAIT: if (bus.mem_rsp_valid) state_next = S_DONE;
      S_DONE: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_shift  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = rd_shift;
    case (f3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_comb begin
    lane_mask = 4'b1111;
    case (f3_q[1:0])
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      res_data_q <= 32'h0;
      res_wen_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        ld_q    <= bus.in_is_load;
        st_q    <= bus.in_is_store;
        f3_q    <= bus.in_funct3;
        addr_q  <= bus.in_addr;
        wdata_q <= bus.in_wdata;
        rd_q    <= bus.in_rd;
        // Non-memory instructions forward the ALU result straight to write-back.
        res_data_q <= is_mem ? 32'h0 : bus.in_addr;
        res_wen_q  <= !is_mem;
        res_err_q  <= acc_err;
      end
      if ((state == S_WAIT) && bus.mem_rsp_valid) begin
        res_data_q <= ld_q ? load_data : 32'h0;
        res_wen_q  <= ld_q;
      end
    end
  end

  assign bus.in_ready      = (state == S_IDLE);
  assign bus.mem_req_valid = (state == S_REQ);
  assign bus.mem_we        = (state == S_REQ) && st_q;
  assign bus.mem_addr      = (state == S_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata     = (state == S_REQ) ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'h0;
  assign bus.mem_wmask     = (state == S_REQ) ? {4'b0000, lane_mask} : 8'h00;

  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = (state == S_DONE) ? res_data_q : 32'h0;
  assign bus.out_rd    = (state == S_DONE) ? rd_q : 5'd0;
  assign bus.out_wen   = (state == S_DONE) && res_wen_q;
  assign bus.out_err   = (state == S_DONE) && res_err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed plus small random-load bench for the LSU; write-back results are
// predicted into a queue when an instruction is issued and popped on out handshake.
module tb_ysyx_24080014_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24080014_lsu_if bus_if ();

  ysyx_24080014_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  logic [38:0] exp_q[$];   // {err, wen, rd, data}
  int tests = 0;
  int fails = 0;
  int bus_hs = 0;
  int out_hs = 0;

  always @(posedge clk) begin
    if (bus_if.mem_req_valid && bus_if.mem_req_ready) bus_hs++;
    if (bus_if.out_valid && bus_if.out_ready) out_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_req(input string name, input logic st, input logic [31:0] e_maddr,
                           input logic [31:0] e_mwdata, input logic [7:0] e_mask);
    check({name, ":req_valid"}, bus_if.mem_req_valid, 1);
    check({name, ":mem_addr"}, bus_if.mem_addr, e_maddr);
    check({name, ":mem_we"}, bus_if.mem_we, st);
    if (st) begin
      check({name, ":mem_wdata"}, bus_if.mem_wdata, e_mwdata);
      check({name, ":mem_wmask"}, bus_if.mem_wmask, e_mask);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*addr[1:0] +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  return {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  task automatic run_op(input string name, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int req_dly, input int rsp_dly, input int out_dly,
                        input logic use_bus, input logic [31:0] e_maddr,
                        input logic [31:0] e_mwdata, input logic [7:0] e_mask,
                        input logic [38:0] e_out);
    logic [38:0] exp;
    exp_q.push_back(e_out);
    @(negedge clk);
    check({name, ":in_ready"}, bus_if.in_ready, 1);
    bus_if.in_valid    = 1'b1;
    bus_if.in_is_load  = ld;
    bus_if.in_is_store = st;
    bus_if.in_funct3   = f3;
    bus_if.in_addr     = addr;
    bus_if.in_wdata    = wdata;
    bus_if.in_rd       = rd;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    if (use_bus) begin
      for (int i = 0; i < req_dly; i++) begin
        check_req({name, ":stall"}, st, e_maddr, e_mwdata, e_mask);
        @(negedge clk);
      end
      check_req(name, st, e_maddr, e_mwdata, e_mask);
      bus_if.mem_req_ready = 1'b1;
      @(negedge clk);
      bus_if.mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
        check({name, ":wait_req"}, bus_if.mem_req_valid, 0);
        check({name, ":wait_out"}, bus_if.out_valid, 0);
        @(negedge clk);
      end
      check({name, ":wait_out"}, bus_if.out_valid, 0);
      bus_if.mem_rsp_valid = 1'b1;
      bus_if.mem_rdata     = rdata;
      @(negedge clk);
      bus_if.mem_rsp_valid = 1'b0;
      bus_if.mem_rdata     = $urandom;
    end else begin
      check({name, ":no_req"}, bus_if.mem_req_valid, 0);
    end
    exp = exp_q[0];
    for (int i = 0; i < out_dly; i++) begin
      check({name, ":hold_valid"}, bus_if.out_valid, 1);
      check({name, ":hold_out"},
            {bus_if.out_err, bus_if.out_wen, bus_if.out_rd, bus_if.out_data}, exp);
      check({name, ":busy"}, bus_if.in_ready, 0);
      @(negedge clk);
    end
    check({name, ":out_valid"}, bus_if.out_valid, 1);
    bus_if.out_ready = 1'b1;
    exp = exp_q.pop_front();
    check({name, ":result"},
          {bus_if.out_err, bus_if.out_wen, bus_if.out_rd, bus_if.out_data}, exp);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check({name, ":out_drop"}, bus_if.out_valid, 0);
    check({name, ":idle"}, bus_if.in_ready, 1);
  endtask

  initial begin
    logic [2:0] f3_tab [5];
    int b0, o0;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    bus_if.in_valid = 0; bus_if.in_is_load = 0; bus_if.in_is_store = 0;
    bus_if.in_funct3 = 0; bus_if.in_addr = 0; bus_if.in_wdata = 0; bus_if.in_rd = 0;
    bus_if.mem_req_ready = 0; bus_if.mem_rsp_valid = 0; bus_if.mem_rdata = 0;
    bus_if.out_ready = 0;

    repeat (2) @(negedge clk);
    check("reset:in_ready", bus_if.in_ready, 1);
    check("reset:req_valid", bus_if.mem_req_valid, 0);
    check("reset:out_valid", bus_if.out_valid, 0);
    check("reset:state", bus_if.dbg_state, 0);
    rst = 1'b0;

    run_op("lb", 1, 0, 3'b000, 32'h8000_0003, 0, 5'd1, 32'h8012_3456, 0, 0, 0,
           1, 32'h8000_0000, 0, 0, {1'b0, 1'b1, 5'd1, 32'hFFFF_FF80});
    run_op("lhu", 1, 0, 3'b101, 32'h8000_0002, 0, 5'd2, 32'hBEEF_1234, 0, 0, 0,
           1, 32'h8000_0000, 0, 0, {1'b0, 1'b1, 5'd2, 32'h0000_BEEF});
    run_op("lh", 1, 0, 3'b001, 32'h8000_0002, 0, 5'd3, 32'hBEEF_1234, 0, 1, 0,
           1, 32'h8000_0000, 0, 0, {1'b0, 1'b1, 5'd3, 32'hFFFF_BEEF});
    run_op("sb", 0, 1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd4, 0, 0, 0, 0,
           1, 32'h8000_0000, 32'h0000_AB00, 8'h02, {1'b0, 1'b0, 5'd4, 32'h0});
    run_op("sh", 0, 1, 3'b001, 32'h8000_0012, 32'h1234_ABCD, 5'd5, 0, 1, 0, 1,
           1, 32'h8000_0010, 32'hABCD_0000, 8'h0C, {1'b0, 1'b0, 5'd5, 32'h0});
    run_op("lw_mis", 1, 0, 3'b010, 32'h8000_0006, 0, 5'd6, 0, 0, 0, 0,
           0, 0, 0, 0, {1'b1, 1'b0, 5'd6, 32'h0});
    run_op("bypass", 0, 0, 3'b000, 32'h1234_5678, 0, 5'd7, 0, 0, 0, 1,
           0, 0, 0, 0, {1'b0, 1'b1, 5'd7, 32'h1234_5678});
    run_op("ld_st", 1, 1, 3'b010, 32'h8000_0000, 0, 5'd8, 0, 0, 0, 0,
           0, 0, 0, 0, {1'b1, 1'b0, 5'd8, 32'h0});
    run_op("bad_f3", 1, 0, 3'b011, 32'h8000_0000, 0, 5'd9, 0, 0, 0, 0,
           0, 0, 0, 0, {1'b1, 1'b0, 5'd9, 32'h0});
    run_op("lhu_mis", 1, 0, 3'b101, 32'h8000_0001, 0, 5'd10, 0, 0, 0, 0,
           0, 0, 0, 0, {1'b1, 1'b0, 5'd10, 32'h0});

    b0 = bus_hs; o0 = out_hs;
    run_op("sw_stall", 0, 1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 5'd11, 0, 5, 3, 2,
           1, 32'h8000_0008, 32'hDEAD_BEEF, 8'h0F, {1'b0, 1'b0, 5'd11, 32'h0});
    check("sw_stall:bus_handshakes", bus_hs - b0, 1);
    check("sw_stall:out_handshakes", out_hs - o0, 1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, rdat;
      logic [4:0]  rd;
      f3   = f3_tab[$urandom_range(0, 4)];
      a    = 32'h8000_1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      rdat = $urandom;
      rd   = 5'($urandom_range(1, 31));
      run_op("rand_ld", 1, 0, f3, a, 0, rd, rdat, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 2), 1, {a[31:2], 2'b00}, 0, 0,
             {1'b0, 1'b1, rd, model_load(f3, a, rdat)});
    end

    // Reset while a load waits for its response.
    @(negedge clk);
    bus_if.in_valid = 1; bus_if.in_is_load = 1; bus_if.in_is_store = 0;
    bus_if.in_funct3 = 3'b010; bus_if.in_addr = 32'h8000_0010; bus_if.in_rd = 5'd12;
    @(negedge clk);
    bus_if.in_valid = 0;
    check("rst:req_valid", bus_if.mem_req_valid, 1);
    bus_if.mem_req_ready = 1;
    @(negedge clk);
    bus_if.mem_req_ready = 0;
    check("rst:in_wait", bus_if.dbg_state, 2);
    b0 = bus_hs;
    #2 rst = 1'b1;
    #1;
    check("rst:in_ready", bus_if.in_ready, 1);
    check("rst:req_valid0", bus_if.mem_req_valid, 0);
    check("rst:out_valid0", bus_if.out_valid, 0);
    check("rst:out_data0", bus_if.out_data, 0);
    check("rst:state", bus_if.dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.mem_rsp_valid = 1; bus_if.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_if.mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst:late_rsp_out", bus_if.out_valid, 0);
      check("rst:no_reissue", bus_if.mem_req_valid, 0);
      @(negedge clk);
    end
    check("rst:bus_handshakes", bus_hs - b0, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
